// File: rtl/ext_pkg.sv
// Shared extension-mode encodings for the immediate/operand extension stage.
package ext_pkg;

  localparam logic [2:0] EXT_SIGN  = 3'b000;
  localparam logic [2:0] EXT_ZERO  = 3'b001;
  localparam logic [2:0] EXT_UPPER = 3'b010;
  localparam logic [2:0] EXT_BR    = 3'b011;
  localparam logic [2:0] EXT_SB    = 3'b100;
  localparam logic [2:0] EXT_ZB    = 3'b101;
  localparam logic [2:0] EXT_SH    = 3'b110;
  localparam logic [2:0] EXT_ZH    = 3'b111;

endpackage

// File: rtl/ext_core.sv
// Purely combinational IN_W -> OUT_W extension mux selected by a 3-bit mode.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int BR_SH = 2
) (
  input  logic [IN_W-1:0]  i_imm,
  input  logic [2:0]       i_eop,
  output logic [OUT_W-1:0] o_data
);

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;

  assign w_sext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
  assign w_zext = {{(OUT_W-IN_W){1'b0}}, i_imm};

  always_comb begin
    o_data = w_sext;
    case (i_eop)
      EXT_SIGN:  o_data = w_sext;
      EXT_ZERO:  o_data = w_zext;
      EXT_UPPER: o_data = {i_imm, {(OUT_W-IN_W){1'b0}}};
      // Bits shifted past the MSB are intentionally discarded.
      EXT_BR:    o_data = w_sext << BR_SH;
      EXT_SB:    o_data = {{(OUT_W-8){i_imm[7]}}, i_imm[7:0]};
      EXT_ZB:    o_data = {{(OUT_W-8){1'b0}}, i_imm[7:0]};
      EXT_SH:    o_data = {{(OUT_W-16){i_imm[15]}}, i_imm[15:0]};
      EXT_ZH:    o_data = {{(OUT_W-16){1'b0}}, i_imm[15:0]};
      default:   o_data = w_sext;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Handshaked extension stage: result registered into a 2-entry FIFO, visible the cycle after push.
// in_ready depends only on occupancy, so a one-cycle downstream stall is absorbed without loss.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int BR_SH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_eop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [OUT_W-1:0] r_data [2];
  logic [TAG_W-1:0] r_tag  [2];
  logic [1:0]       r_cnt;
  logic             r_head;
  logic             r_tail;

  logic [OUT_W-1:0] w_ext;
  logic             w_push;
  logic             w_pop;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .BR_SH (BR_SH)
  ) u_core (
    .i_imm  (in_imm),
    .i_eop  (in_eop),
    .o_data (w_ext)
  );

  assign in_ready  = (r_cnt != 2'd2);
  assign out_valid = (r_cnt != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign out_data  = out_valid ? r_data[r_head] : '0;
  assign out_tag   = out_valid ? r_tag[r_head]  : '0;

  // Flush clears exactly like reset; a same-cycle push is dropped and a same-cycle pop is moot.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_cnt     <= 2'd0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_tag[0]  <= '0;
      r_tag[1]  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_tail] <= w_ext;
        r_tag[r_tail]  <= in_tag;
        r_tail         <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: extension modes, stall, back-to-back, flush and reset.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_eop;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int nchk  = 0;
  int nfail = 0;

  ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SH(2), .TAG_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_eop    (in_eop),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stalled(input logic [4:0] tag);
    in_valid = 1'b1; in_imm = 16'h0001; in_eop = 3'b001; in_tag = tag;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_imm = '0; in_eop = '0; in_tag = '0;
    step(); step();
    reset = 1'b0;
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    nchk++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    nchk++; if (out_data !== 32'h0) begin nfail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    nchk++; if (out_tag !== 5'h0) begin nfail++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
  endtask

  task automatic test_modes();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hFFFF8001; exp_d[1] = 32'h00008001;
    exp_d[2] = 32'h80010000; exp_d[3] = 32'hFFFE0004;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_imm = 16'h8001; in_eop = 3'(i); in_tag = 5'(i + 1);
      step();
      nchk++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL mode%0d_valid got=%0b exp=1", i, out_valid); end
      nchk++; if (out_data !== exp_d[i]) begin nfail++; $display("FAIL mode%0d_data got=%h exp=%h", i, out_data, exp_d[i]); end
      nchk++; if (out_tag !== 5'(i + 1)) begin nfail++; $display("FAIL mode%0d_tag got=%0d exp=%0d", i, out_tag, i + 1); end
    end
    in_valid = 1'b0;
    step();
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL modes_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_byte_half();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hFFFFFF80; exp_d[1] = 32'h00000080;
    exp_d[2] = 32'h00007F80; exp_d[3] = 32'h00007F80;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_imm = 16'h7F80; in_eop = 3'(4 + i); in_tag = 5'(i);
      step();
      nchk++; if (out_data !== exp_d[i]) begin nfail++; $display("FAIL bh_eop%0d_data got=%h exp=%h", 4 + i, out_data, exp_d[i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    push_stalled(5'd3);
    nchk++; if (out_tag !== 5'd3 || in_ready !== 1'b1) begin nfail++; $display("FAIL stall_first got tag=%0d rdy=%0b exp tag=3 rdy=1", out_tag, in_ready); end
    push_stalled(5'd7);
    nchk++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL stall_full_rdy got=%0b exp=0", in_ready); end
    push_stalled(5'd9);
    nchk++; if (out_tag !== 5'd3 || out_valid !== 1'b1) begin nfail++; $display("FAIL stall_hold got tag=%0d vld=%0b exp tag=3 vld=1", out_tag, out_valid); end
    out_ready = 1'b1;
    step();
    nchk++; if (out_tag !== 5'd7 || out_valid !== 1'b1) begin nfail++; $display("FAIL stall_second got tag=%0d vld=%0b exp tag=7 vld=1", out_tag, out_valid); end
    step();
    nchk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nfail++; $display("FAIL stall_empty got vld=%0b rdy=%0b exp vld=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    push_stalled(5'd10);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nchk++; if (out_tag !== 5'(10 + i)) begin nfail++; $display("FAIL b2b_head%0d got=%0d exp=%0d", i, out_tag, 10 + i); end
      in_valid = 1'b1; in_imm = 16'h0001; in_eop = 3'b001; in_tag = 5'(11 + i);
      step();
      nchk++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin nfail++; $display("FAIL b2b_cnt%0d got vld=%0b rdy=%0b exp 1/1", i, out_valid, in_ready); end
    end
    in_valid = 1'b0;
    nchk++; if (out_tag !== 5'd20) begin nfail++; $display("FAIL b2b_last got=%0d exp=20", out_tag); end
    step();
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push_stalled(5'd1);
    push_stalled(5'd2);
    flush = 1'b1; in_valid = 1'b1; in_tag = 5'd5;
    step();
    flush = 1'b0; in_valid = 1'b0;
    nchk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin nfail++; $display("FAIL flush_state got vld=%0b rdy=%0b data=%h exp 0/1/0", out_valid, in_ready, out_data); end
    out_ready = 1'b1;
    step();
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL flush_no_ghost got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    push_stalled(5'd1);
    push_stalled(5'd2);
    reset = 1'b1; in_valid = 1'b1; in_tag = 5'd4;
    step();
    nchk++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0 || in_ready !== 1'b1) begin nfail++; $display("FAIL rst_stall got vld=%0b data=%h tag=%0d rdy=%0b exp 0/0/0/1", out_valid, out_data, out_tag, in_ready); end
    step();
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_hold_push got=%0b exp=0", out_valid); end
    reset = 1'b0; in_valid = 1'b1; in_imm = 16'h0005; in_eop = 3'b001; in_tag = 5'd6;
    step();
    in_valid = 1'b0;
    nchk++; if (out_valid !== 1'b1 || out_tag !== 5'd6 || out_data !== 32'h5) begin nfail++; $display("FAIL rst_after got vld=%0b tag=%0d data=%h exp 1/6/5", out_valid, out_tag, out_data); end
    out_ready = 1'b1;
    step();
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_after_drain got=%0b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_byte_half();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_stall();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
